mandala_sequencer: RTL and testbench
====================================

MANDALA_SEQUENCER -- requirements
Module: mandala_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 clk  input  1  pixel clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 vsync  input  1  vertical sync from the sync generator, same clock domain, active high.
REQ-005 run  input  1  asynchronous control; 1 = free-running animation.
REQ-006 step  input  1  asynchronous control; a rising edge requests one advance while paused.
REQ-007 dir  input  1  asynchronous control; 0 = count up, 1 = count down.
REQ-008 speed  input  2  asynchronous control; advance every 2^speed frames (1, 2, 4 or 8).
REQ-009 build  input  1  asynchronous control; 1 = layer build-up mode, 0 = all layers on.
REQ-010 pattern_phase  output  10  pattern offset consumed by the mandala datapath.
REQ-011 color_phase  output  8  colour offset consumed by the mandala datapath.
REQ-012 layer_mask  output  8  per-layer enable; bit n gates ring n+1.
REQ-013 frame_tick  output  1  one-cycle pulse per detected vsync rising edge.
REQ-014 seq_state  output  2  current FSM state encoding, for debug.

Function
REQ-015 run, step, dir, speed and build SHALL each pass through a 2-flop synchroniser before use; vsync SHALL NOT be synchronised.
REQ-016 A vsync rising edge SHALL be detected as vsync=1 with vsync_q=0; frame_tick SHALL be high for exactly the following cycle.
REQ-017 Synchronised dir, speed and build SHALL be latched into shadow registers only on frame_tick, so they never change mid-frame.
REQ-018 The FSM SHALL have the states IDLE=0, RUN=1, PAUSE=2 and STEP=3.
REQ-019 IDLE SHALL go to RUN (run=1) or PAUSE (run=0) on the first frame_tick.
REQ-020 PAUSE SHALL go to RUN on frame_tick with run=1, or to STEP on a synchronised step rising edge with run=0.
REQ-021 STEP SHALL perform exactly one advance on the next frame_tick and then enter PAUSE; run=1 in that cycle SHALL go to RUN instead.
REQ-022 RUN SHALL go to PAUSE on frame_tick with run=0.
REQ-023 Step edges in RUN or STEP SHALL be ignored and SHALL NOT be queued.
REQ-024 In RUN a 3-bit frame divider SHALL count frame_ticks and advance when divider == 2^speed - 1, then clear.
REQ-025 The divider SHALL hold its value in PAUSE and SHALL clear on entry to STEP.
REQ-026 An advance SHALL change pattern_phase by +1 or -1 modulo 1024 and color_phase by +1 or -1 modulo 256, according to shadow dir.
REQ-027 Wrap cases: 1023 to 0 and 255 to 0 when counting up; 0 to 1023 and 0 to 255 when counting down.
REQ-028 With shadow build=0, layer_mask SHALL be 8'hFF.
REQ-029 With shadow build=1, each advance SHALL set layer_mask = {mask[6:0], 1}; 8'hFF SHALL be followed by 8'h01.
REQ-030 When build goes from 0 to 1, layer_mask SHALL load 8'h01 on that frame_tick.
REQ-031 The outputs SHALL update in the cycle after frame_tick, giving a latency of 2 clocks from the vsync rise.
REQ-032 The outputs SHALL be registered and SHALL hold stable between advances.

Reset
REQ-033 Reset values: pattern_phase=0, color_phase=0, layer_mask=8'hFF, frame_tick=0, seq_state=IDLE, divider=0, synchronisers=0, shadows=0.
REQ-034 Asserting rst_n mid-frame or mid-divide SHALL return all state to reset values immediately; after release the block SHALL wait in IDLE for the next vsync rise.

Structure
REQ-035 The package mandala_pkg SHALL hold the state encodings, PATTERN_W=10, COLOR_W=8, LAYERS=8 and the LAYER_ALL=8'hFF constant.
REQ-036 The synchroniser SHALL be one reusable sub-module, sync_2ff, instantiated once per control bit.
REQ-037 The FSM, divider and phase counters SHALL live in mandala_sequencer; the target size is 120-400 lines.

Verification
REQ-038 Reset, run=1, speed=0, dir=0: after 3 vsync rises, pattern_phase=3 and color_phase=3, each update 2 clocks after its vsync rise.
REQ-039 run=1, speed=2: 8 vsync rises produce exactly 2 advances; changing speed mid-frame takes effect only from the next vsync.
REQ-040 Preload to pattern_phase=1023, color_phase=255 with dir=0, then one advance: values are 0 and 0; with dir=1 from 0: values are 1023 and 255.
REQ-041 run=0, one step pulse then three vsyncs: exactly one advance and seq_state=PAUSE; a step during RUN causes no extra advance.
REQ-042 build=1, run=1, speed=0: layer_mask sequence 01, 03, 07, ..., FF, 01 over 9 advances.
REQ-043 Assert rst_n while in RUN with divider=3: all outputs return to reset values asynchronously; the first advance occurs only after a vsync rise following IDLE exit.

Source files
------------

// File: rtl/mandala_pkg.sv
// mandala_pkg: shared widths, FSM encoding, control bundle and the layer
// build-up helper for the mandala sequencer.
package mandala_pkg;

  localparam int PATTERN_W = 10;
  localparam int COLOR_W   = 8;
  localparam int LAYERS    = 8;
  localparam logic [LAYERS-1:0] LAYER_ALL = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_STEP  = 2'd3
  } seq_state_e;

  // Asynchronous control inputs, bundled so they can be synchronised bit-wise.
  typedef struct packed {
    logic       run;
    logic       step;
    logic       dir;
    logic [1:0] speed;
    logic       build;
  } ctrl_t;

  // Build-up: shift a new ring in; once every ring is lit, restart from ring 1.
  function automatic logic [LAYERS-1:0] next_layer(input logic [LAYERS-1:0] m);
    return (m == LAYER_ALL) ? LAYERS'(1) : {m[LAYERS-2:0], 1'b1};
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for one asynchronous control bit.
//   clk, rst_n : clock, async active-low reset (both flops clear to 0)
//   d          : asynchronous input
//   q          : synchronised output, two clocks behind d
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/mandala_sequencer.sv
// mandala_sequencer: frame-locked animation sequencer for the mandala datapath.
// Detects vsync rises, runs an IDLE/RUN/PAUSE/STEP FSM with a frame divider,
// and advances pattern/colour phases and the layer build-up mask.
//   clk, rst_n      : pixel clock, async active-low reset
//   vsync           : vertical sync, same clock domain, active high
//   run/step/dir/speed/build : asynchronous controls (synchronised here)
//   pattern_phase   : 10-bit pattern offset
//   color_phase     : 8-bit colour offset
//   layer_mask      : per-ring enable, bit n gates ring n+1
//   frame_tick      : one-cycle pulse per vsync rise
//   seq_state       : FSM state, for debug
import mandala_pkg::*;

module mandala_sequencer (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vsync,
  input  logic                 run,
  input  logic                 step,
  input  logic                 dir,
  input  logic [1:0]           speed,
  input  logic                 build,
  output logic [PATTERN_W-1:0] pattern_phase,
  output logic [COLOR_W-1:0]   color_phase,
  output logic [LAYERS-1:0]    layer_mask,
  output logic                 frame_tick,
  output logic [1:0]           seq_state
);
  localparam int CTRL_W = $bits(ctrl_t);

  // ---- control synchronisers, one instance per bit ----
  logic [CTRL_W-1:0] ctrl_raw_v, ctrl_s_v;
  ctrl_t             ctrl_s;

  assign ctrl_raw_v = {run, step, dir, speed, build};
  assign ctrl_s     = ctrl_t'(ctrl_s_v);

  genvar gi;
  generate
    for (gi = 0; gi < CTRL_W; gi++) begin : g_sync
      sync_2ff u_sync (.clk(clk), .rst_n(rst_n), .d(ctrl_raw_v[gi]), .q(ctrl_s_v[gi]));
    end
  endgenerate

  // ---- state ----
  seq_state_e  state;
  logic        vsync_q, step_q;
  logic        dir_sh, build_sh;
  logic [1:0]  speed_sh;
  logic [2:0]  div;

  // ---- combinational decode ----
  logic        vs_rise, step_rise;
  logic        dir_e, build_e;
  logic [1:0]  speed_e;
  logic [2:0]  div_max;
  logic        count_frame, div_hit, to_step, advance;

  assign vs_rise   = vsync & ~vsync_q;
  assign step_rise = ctrl_s.step & ~step_q;

  // On a frame tick the shadows are being loaded, so that tick already acts on
  // the freshly sampled settings; in between, the shadows hold them frozen.
  assign dir_e   = frame_tick ? ctrl_s.dir   : dir_sh;
  assign speed_e = frame_tick ? ctrl_s.speed : speed_sh;
  assign build_e = frame_tick ? ctrl_s.build : build_sh;

  assign div_max = (3'd1 << speed_e) - 3'd1;
  // >= rather than == so a speed reduction while the divider is past the new
  // limit advances on the next frame instead of wrapping through 7.
  assign div_hit = (div >= div_max);

  // Any frame tick with run high outside STEP is a running frame, including
  // the ticks that leave IDLE or PAUSE for RUN.
  assign count_frame = frame_tick && ctrl_s.run && (state != ST_STEP);
  assign to_step     = (state == ST_PAUSE) && step_rise && !ctrl_s.run;
  assign advance     = (count_frame && div_hit) || (frame_tick && state == ST_STEP);

  assign seq_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      vsync_q       <= 1'b0;
      frame_tick    <= 1'b0;
      step_q        <= 1'b0;
      dir_sh        <= 1'b0;
      speed_sh      <= 2'd0;
      build_sh      <= 1'b0;
      div           <= 3'd0;
      pattern_phase <= '0;
      color_phase   <= '0;
      layer_mask    <= LAYER_ALL;
    end else begin
      vsync_q    <= vsync;
      frame_tick <= vs_rise;
      step_q     <= ctrl_s.step;

      if (frame_tick) begin
        dir_sh   <= ctrl_s.dir;
        speed_sh <= ctrl_s.speed;
        build_sh <= ctrl_s.build;
      end

      // Divider: counts running frames, holds in PAUSE, clears entering STEP.
      if (count_frame)  div <= div_hit ? 3'd0 : div + 3'd1;
      else if (to_step) div <= 3'd0;

      if (advance) begin
        pattern_phase <= dir_e ? pattern_phase - PATTERN_W'(1) : pattern_phase + PATTERN_W'(1);
        color_phase   <= dir_e ? color_phase - COLOR_W'(1)     : color_phase + COLOR_W'(1);
      end

      // Build mode switching on restarts from ring 1, overriding that tick's shift.
      if (frame_tick) begin
        if (!build_e)       layer_mask <= LAYER_ALL;
        else if (!build_sh) layer_mask <= LAYERS'(1);
        else if (advance)   layer_mask <= next_layer(layer_mask);
      end

      unique case (state)
        ST_IDLE:  if (frame_tick) state <= ctrl_s.run ? ST_RUN : ST_PAUSE;
        ST_RUN:   if (frame_tick && !ctrl_s.run) state <= ST_PAUSE;
        ST_PAUSE: begin
          if (frame_tick && ctrl_s.run) state <= ST_RUN;
          else if (to_step)             state <= ST_STEP;
        end
        ST_STEP:  if (frame_tick) state <= ctrl_s.run ? ST_RUN : ST_PAUSE;
        default:  state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mandala_sequencer.sv
module tb_mandala_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b0, run = 1'b0, step = 1'b0, dir = 1'b0, build = 1'b0;
  logic [1:0] speed = 2'd0;
  logic [9:0] pattern_phase;
  logic [7:0] color_phase, layer_mask;
  logic       frame_tick;
  logic [1:0] seq_state;

  int n_chk  = 0;
  int n_fail = 0;

  mandala_sequencer dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .run(run), .step(step), .dir(dir),
    .speed(speed), .build(build), .pattern_phase(pattern_phase),
    .color_phase(color_phase), .layer_mask(layer_mask), .frame_tick(frame_tick),
    .seq_state(seq_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       run;
    logic       dir;
    logic [1:0] speed;
    logic       build;
    logic [9:0] p;
    logic [7:0] c;
    logic [7:0] m;
    logic [1:0] st;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  function automatic vec_t row(logic r, logic rn, logic d, logic [1:0] s, logic b,
                               logic [9:0] p, logic [7:0] c, logic [7:0] m, logic [1:0] st);
    vec_t v;
    v.rst = r; v.run = rn; v.dir = d; v.speed = s; v.build = b;
    v.p = p; v.c = c; v.m = m; v.st = st;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Rise on a negedge, one cycle high; outputs settle by the final negedge.
  task automatic vsync_pulse();
    @(negedge clk); vsync = 1'b1;
    @(negedge clk); vsync = 1'b0;
    @(negedge clk);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  task automatic step_pulse();
    @(negedge clk); step = 1'b1;
    repeat (4) @(negedge clk);
    step = 1'b0;
    settle();
  endtask

  initial begin
    // rst run dir spd bld   p   c   mask  state
    vecs[0]  = row(1, 1, 0, 0, 0, 1,  1,  8'hFF, 1);
    vecs[1]  = row(0, 1, 0, 0, 0, 2,  2,  8'hFF, 1);
    vecs[2]  = row(0, 1, 0, 0, 0, 3,  3,  8'hFF, 1);
    vecs[3]  = row(0, 1, 0, 2, 0, 3,  3,  8'hFF, 1);
    vecs[4]  = row(0, 1, 0, 2, 0, 3,  3,  8'hFF, 1);
    vecs[5]  = row(0, 1, 0, 2, 0, 3,  3,  8'hFF, 1);
    vecs[6]  = row(0, 1, 0, 2, 0, 4,  4,  8'hFF, 1);
    vecs[7]  = row(0, 1, 0, 2, 0, 4,  4,  8'hFF, 1);
    vecs[8]  = row(0, 1, 0, 2, 0, 4,  4,  8'hFF, 1);
    vecs[9]  = row(0, 1, 0, 2, 0, 4,  4,  8'hFF, 1);
    vecs[10] = row(0, 1, 0, 2, 0, 5,  5,  8'hFF, 1);
    vecs[11] = row(0, 1, 1, 0, 0, 4,  4,  8'hFF, 1);
    vecs[12] = row(0, 1, 1, 0, 0, 3,  3,  8'hFF, 1);
    vecs[13] = row(1, 1, 0, 0, 1, 1,  1,  8'h01, 1);
    vecs[14] = row(0, 1, 0, 0, 1, 2,  2,  8'h03, 1);
    vecs[15] = row(0, 1, 0, 0, 1, 3,  3,  8'h07, 1);
    vecs[16] = row(0, 1, 0, 0, 1, 4,  4,  8'h0F, 1);
    vecs[17] = row(0, 1, 0, 0, 1, 5,  5,  8'h1F, 1);
    vecs[18] = row(0, 1, 0, 0, 1, 6,  6,  8'h3F, 1);
    vecs[19] = row(0, 1, 0, 0, 1, 7,  7,  8'h7F, 1);
    vecs[20] = row(0, 1, 0, 0, 1, 8,  8,  8'hFF, 1);
    vecs[21] = row(0, 1, 0, 0, 1, 9,  9,  8'h01, 1);
    vecs[22] = row(0, 1, 0, 0, 0, 10, 10, 8'hFF, 1);
    vecs[23] = row(0, 0, 0, 0, 0, 10, 10, 8'hFF, 2);
    vecs[24] = row(0, 0, 0, 0, 0, 10, 10, 8'hFF, 2);
    vecs[25] = row(0, 1, 0, 0, 0, 11, 11, 8'hFF, 1);

    // Reset state
    do_reset();
    check("rst_pattern", 32'(pattern_phase), 0);
    check("rst_color",   32'(color_phase),   0);
    check("rst_mask",    32'(layer_mask),    32'hFF);
    check("rst_tick",    32'(frame_tick),    0);
    check("rst_state",   32'(seq_state),     0);

    // Table: one vsync per row
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].rst) do_reset();
      run = vecs[i].run; dir = vecs[i].dir; speed = vecs[i].speed; build = vecs[i].build;
      settle();
      vsync_pulse();
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_pattern", i), 32'(pattern_phase), 32'(vecs[i].p));
      check($sformatf("v%0d_color", i),   32'(color_phase),   32'(vecs[i].c));
      check($sformatf("v%0d_mask", i),    32'(layer_mask),    32'(vecs[i].m));
      check($sformatf("v%0d_state", i),   32'(seq_state),     32'(vecs[i].st));
    end

    // Latency: tick one clock after the rise, outputs two clocks after
    run = 1'b1; dir = 1'b0; speed = 2'd0; build = 1'b0;
    do_reset();
    settle();
    @(negedge clk); vsync = 1'b1;
    @(negedge clk); vsync = 1'b0;
    check("lat_tick_hi",  32'(frame_tick),    1);
    check("lat_p_old",    32'(pattern_phase), 0);
    @(negedge clk);
    check("lat_tick_lo",  32'(frame_tick),    0);
    check("lat_p_new",    32'(pattern_phase), 1);

    // Speed change mid-frame takes effect at the next vsync
    speed = 2'd2;
    do_reset();
    settle();
    vsync_pulse(); settle();
    check("spd_p_before", 32'(pattern_phase), 0);
    speed = 2'd0;
    repeat (10) @(negedge clk);
    check("spd_p_midframe", 32'(pattern_phase), 0);
    vsync_pulse(); settle();
    check("spd_p_after", 32'(pattern_phase), 1);

    // Wrap up: 1023 advances then one more
    speed = 2'd0; dir = 1'b0;
    do_reset();
    settle();
    for (int k = 0; k < 1023; k++) vsync_pulse();
    settle();
    check("wrap_p_1023", 32'(pattern_phase), 1023);
    check("wrap_c_255",  32'(color_phase),   255);
    vsync_pulse(); settle();
    check("wrap_up_p", 32'(pattern_phase), 0);
    check("wrap_up_c", 32'(color_phase),   0);
    // Wrap down from 0
    dir = 1'b1;
    do_reset();
    settle();
    vsync_pulse(); settle();
    check("wrap_dn_p", 32'(pattern_phase), 1023);
    check("wrap_dn_c", 32'(color_phase),   255);

    // Single step while paused
    run = 1'b0; dir = 1'b0;
    do_reset();
    settle();
    vsync_pulse(); settle();
    check("step_idle_pause", 32'(seq_state), 2);
    step_pulse();
    check("step_state", 32'(seq_state), 3);
    check("step_no_adv_yet", 32'(pattern_phase), 0);
    repeat (3) begin vsync_pulse(); settle(); end
    check("step_one_adv", 32'(pattern_phase), 1);
    check("step_back_pause", 32'(seq_state), 2);
    // Step during RUN is ignored
    run = 1'b1; settle();
    vsync_pulse(); settle();
    check("resume_p", 32'(pattern_phase), 2);
    step_pulse();
    check("run_step_state", 32'(seq_state), 1);
    vsync_pulse(); settle();
    check("run_step_p", 32'(pattern_phase), 3);

    // Async reset mid-divide
    run = 1'b1; speed = 2'd0;
    do_reset();
    settle();
    vsync_pulse(); vsync_pulse(); settle();
    speed = 2'd3; settle();
    repeat (3) vsync_pulse();
    settle();
    check("mid_p_before", 32'(pattern_phase), 2);
    @(negedge clk); #2 rst_n = 1'b0; #1;
    check("async_p",    32'(pattern_phase), 0);
    check("async_c",    32'(color_phase),   0);
    check("async_mask", 32'(layer_mask),    32'hFF);
    check("async_tick", 32'(frame_tick),    0);
    check("async_st",   32'(seq_state),     0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_idle", 32'(seq_state), 0);
    vsync_pulse(); settle();
    check("post_rst_exit_st", 32'(seq_state), 1);
    check("post_rst_no_adv", 32'(pattern_phase), 0);
    speed = 2'd0; settle();
    vsync_pulse(); settle();
    check("post_rst_first_adv", 32'(pattern_phase), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
